// File: rtl/bf_led_monitor.sv
// bf_led_monitor
// Passive checker for the bound-flasher LED bus. Samples the 16-bit
// thermometer LED word every clock, decodes level/direction/phase and
// checks each step against the six-phase sweep 16,6,11,0,6,0 (with
// flick kickbacks). Reports completions, aborts and protocol errors.
//
// Ports
//   clk       in   rising-edge clock (LED source domain)
//   reset     in   asynchronous active-low reset
//   led[15:0] in   observed LED word (legal = thermometer from bit 0)
//   flick     in   observed flick of the source
//   level[4:0]     lit LED count of the last sample
//   state[1:0]     0 IDLE, 1 UP, 2 DOWN, 3 SYNC
//   phase[2:0]     sequence phase 0..5 (0 in IDLE/SYNC)
//   done/kick/abort/err   one-cycle event pulses (mutually exclusive)
//   err_code[2:0]  first error since reset (sticky)
//   seq_cnt[7:0]   completed sequences, saturating
//
// Build option: BF_MON_FLICK_CHECK_EN -- when defined, starts and
// kickbacks require flick high at this edge or the previous one.
module bf_led_monitor (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] led,
  input  logic        flick,
  output logic [4:0]  level,
  output logic [1:0]  state,
  output logic [2:0]  phase,
  output logic        done,
  output logic        kick,
  output logic        abort,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [7:0]  seq_cnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_SYNC = 2'd3} st_e;

  localparam logic [2:0] E_THERM = 3'd1;
  localparam logic [2:0] E_STEP  = 3'd2;
  localparam logic [2:0] E_SEQ   = 3'd3;
  localparam logic [2:0] E_FLICK = 3'd4;

  st_e        state_q, state_d;
  logic [2:0] phase_q, phase_d;
  logic [4:0] level_q;
  logic       done_q, done_d, kick_q, kick_d, abort_q, abort_d, err_q, err_d;
  logic [2:0] err_code_q, err_code_d, ecode;
  logic [7:0] seq_q, seq_d;

  logic [4:0] l_cur, l_prv, tgt;
  logic       thermo, step_up, step_dn, flick_ok;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  function automatic logic [4:0] phase_tgt(input logic [2:0] p);
    case (p)
      3'd0:    return 5'd16;
      3'd1:    return 5'd6;
      3'd2:    return 5'd11;
      3'd4:    return 5'd6;
      default: return 5'd0;
    endcase
  endfunction

  // level_q is the popcount of the previous sample, so it doubles as Lq;
  // the previous LED word itself is never needed beyond its level.
  assign l_cur   = popcnt(led);
  assign l_prv   = level_q;
  assign thermo  = ((led & (led + 16'd1)) == 16'd0);
  assign step_up = (l_cur == l_prv + 5'd1);
  assign step_dn = (l_cur + 5'd1 == l_prv);
  assign tgt     = phase_tgt(phase_q);

`ifdef BF_MON_FLICK_CHECK_EN
  logic flick_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flick_q <= 1'b0;
    else        flick_q <= flick;
  end
  assign flick_ok = flick | flick_q;
`else
  // flick is observed but never gates acceptance in this build.
  assign flick_ok = flick | 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    done_d     = 1'b0;
    kick_d     = 1'b0;
    abort_d    = 1'b0;
    err_d      = 1'b0;
    ecode      = 3'd0;
    err_code_d = err_code_q;
    seq_d      = seq_q;
    case (state_q)
      S_IDLE: begin
        if (!thermo) begin
          err_d = 1'b1; ecode = E_THERM;
        end else if (l_cur == 5'd0) begin
          state_d = S_IDLE;
        end else if (l_cur == 5'd1) begin
          if (!flick_ok) begin
            err_d = 1'b1; ecode = E_FLICK;
          end else begin
            state_d = S_UP; phase_d = 3'd0;
          end
        end else begin
          err_d = 1'b1; ecode = E_STEP;
        end
      end
      S_UP, S_DOWN: begin
        if (!thermo) begin
          err_d = 1'b1; ecode = E_THERM;
        end else if (l_cur == 5'd0 && l_prv >= 5'd2) begin
          abort_d = 1'b1; state_d = S_IDLE; phase_d = 3'd0;
        end else if (!(step_up || step_dn)) begin
          err_d = 1'b1; ecode = E_STEP;
        end else if (state_q == S_UP) begin
          if (step_up) begin
            if (l_cur > tgt) begin err_d = 1'b1; ecode = E_SEQ; end
          end else if (l_prv == tgt) begin
            state_d = S_DOWN; phase_d = phase_q + 3'd1;
          end else begin
            err_d = 1'b1; ecode = E_SEQ;
          end
        end else begin
          if (step_dn) begin
            if (l_cur < tgt) begin
              err_d = 1'b1; ecode = E_SEQ;
            end else if (phase_q == 3'd5 && l_cur == 5'd0) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              phase_d = 3'd0;
              if (seq_q != 8'hFF) seq_d = seq_q + 8'd1;
            end
          end else if (l_prv == tgt && (phase_q == 3'd1 || phase_q == 3'd3)) begin
            state_d = S_UP; phase_d = phase_q + 3'd1;
          end else if ((l_prv == 5'd0 || l_prv == 5'd6) && l_prv != tgt && phase_q != 3'd5) begin
            // Kickback: re-enter the previous UP phase from a flick point.
            if (!flick_ok) begin
              err_d = 1'b1; ecode = E_FLICK;
            end else begin
              kick_d = 1'b1; state_d = S_UP; phase_d = phase_q - 3'd1;
            end
          end else begin
            err_d = 1'b1; ecode = E_SEQ;
          end
        end
      end
      S_SYNC: begin
        // Silent resynchronisation: only an all-dark bus lets us restart.
        if (l_cur == 5'd0) begin state_d = S_IDLE; phase_d = 3'd0; end
      end
      default: state_d = S_SYNC;
    endcase
    if (err_d) begin
      state_d = S_SYNC;
      phase_d = 3'd0;
      if (err_code_q == 3'd0) err_code_d = ecode;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 3'd0;
      level_q    <= 5'd0;
      done_q     <= 1'b0;
      kick_q     <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
      seq_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      level_q    <= l_cur;
      done_q     <= done_d;
      kick_q     <= kick_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      seq_q      <= seq_d;
    end
  end

  assign level    = level_q;
  assign state    = state_q;
  assign phase    = phase_q;
  assign done     = done_q;
  assign kick     = kick_q;
  assign abort    = abort_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign seq_cnt  = seq_q;

endmodule

// File: tb/tb_bf_led_monitor.sv
module tb_bf_led_monitor;

`ifdef BF_MON_FLICK_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif
  localparam int IDLE = 0, UP = 1, DOWN = 2, SYNC = 3;

  logic        clk = 1'b0, reset = 1'b0, flick = 1'b0;
  logic [15:0] led = 16'd0;
  logic [4:0]  level;
  logic [1:0]  state;
  logic [2:0]  phase, err_code;
  logic        done, kick, abort, err;
  logic [7:0]  seq_cnt;

  bf_led_monitor dut (
    .clk(clk), .reset(reset), .led(led), .flick(flick),
    .level(level), .state(state), .phase(phase), .done(done), .kick(kick),
    .abort(abort), .err(err), .err_code(err_code), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: sequence position as plain integers; direction is
  // implied by phase parity, legality by "what the next level may be".
  int TGT[6] = '{16, 6, 11, 0, 6, 0};
  int m_st, m_ph, m_lq, m_code, m_cnt;
  bit m_fprev, e_done, e_kick, e_abort, e_err;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] therm(input int n);
    logic [31:0] v;
    v = (32'd1 << n) - 32'd1;
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_st = IDLE; m_ph = 0; m_lq = 0; m_code = 0; m_cnt = 0; m_fprev = 0;
    e_done = 0; e_kick = 0; e_abort = 0; e_err = 0;
  endtask

  task automatic raise(input int c);
    e_err = 1;
    if (m_code == 0) m_code = c;
    m_st = SYNC; m_ph = 0;
  endtask

  task automatic model_step(input logic [15:0] w, input bit f);
    int L, tg; bit th, dn, fl_ok;
    L = $countones(w);
    th = (w == therm(L));
    fl_ok = !FCHK || f || m_fprev;
    e_done = 0; e_kick = 0; e_abort = 0; e_err = 0;
    if (m_st == SYNC) begin
      if (L == 0) begin m_st = IDLE; m_ph = 0; end
    end else if (!th) raise(1);
    else if (m_st == IDLE) begin
      if (L == 1) begin
        if (!fl_ok) raise(4); else begin m_st = UP; m_ph = 0; end
      end else if (L != 0) raise(2);
    end else if (L == 0 && m_lq >= 2) begin
      e_abort = 1; m_st = IDLE; m_ph = 0;
    end else if (L - m_lq != 1 && m_lq - L != 1) raise(2);
    else begin
      tg = TGT[m_ph];
      dn = m_ph[0];
      if (L == (dn ? m_lq - 1 : m_lq + 1)) begin
        if (dn ? (L < tg) : (L > tg)) raise(3);
        else if (dn && m_ph == 5 && L == 0) begin
          e_done = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; m_st = IDLE; m_ph = 0;
        end
      end else if (m_lq == tg && (!dn || m_ph == 1 || m_ph == 3)) begin
        m_ph = m_ph + 1; m_st = dn ? UP : DOWN;
      end else if (dn && (m_lq == 0 || m_lq == 6) && m_lq != tg && m_ph != 5) begin
        if (!fl_ok) raise(4);
        else begin e_kick = 1; m_ph = m_ph - 1; m_st = UP; end
      end else raise(3);
    end
    m_lq = L; m_fprev = f;
  endtask

  task automatic compare_all();
    chk("level", level, m_lq);
    chk("state", state, m_st);
    chk("phase", phase, m_ph);
    chk("done", done, e_done);
    chk("kick", kick, e_kick);
    chk("abort", abort, e_abort);
    chk("err", err, e_err);
    chk("err_code", err_code, m_code);
    chk("seq_cnt", seq_cnt, m_cnt);
  endtask

  task automatic step(input logic [15:0] w, input bit f);
    led = w; flick = f;
    model_step(w, f);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Choose the next stimulus word: a legal continuation, optionally a
  // kickback, optionally a deliberately corrupted word.
  task automatic pick(input int err_pct, input int kick_pct, output logic [15:0] w, output bit f);
    int lv, tg;
    tg = TGT[m_ph];
    case (m_st)
      IDLE:    lv = ($urandom_range(0, 3) == 0) ? 0 : 1;
      UP:      lv = (m_lq == tg) ? m_lq - 1 : m_lq + 1;
      DOWN: begin
        if (m_lq == tg) lv = m_lq + 1;
        else if ((m_lq == 0 || m_lq == 6) && m_ph != 5 && $urandom_range(0, 99) < kick_pct) lv = m_lq + 1;
        else lv = m_lq - 1;
      end
      default: lv = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 16) : 0;
    endcase
    w = therm(lv);
    f = (err_pct == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if ($urandom_range(0, 99) < err_pct) begin
      case ($urandom_range(0, 4))
        0: w = 16'($urandom);
        1: w = 16'd0;
        2: w = therm(m_lq);
        3: w = therm((m_lq + 2 > 16) ? 16 : m_lq + 2);
        default: w = therm($urandom_range(0, 16));
      endcase
    end
  endtask

  task automatic walk_to(input int st, input int ph, input int lq);
    logic [15:0] w; bit f, hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      if (m_st == st && m_ph == ph && m_lq == lq) hit = 1;
      else begin pick(0, 0, w, f); step(w, f); end
    end
    chk("walk_to_reached", hit, 1);
  endtask

  task automatic run_until_done();
    logic [15:0] w; bit f, hit;
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      pick(0, 0, w, f); step(w, f);
      hit = e_done;
    end
    chk("sweep_completed", hit, 1);
  endtask

  initial begin
    logic [15:0] w; bit f;
    do_reset();

    // Full legal sweep
    run_until_done();
    chk("sweep_done_pulse", done, 1);
    chk("sweep_seq_cnt", seq_cnt, 1);
    chk("sweep_err_code", err_code, 0);
    step(16'd0, 1);
    chk("done_one_cycle", done, 0);

    // Kickback in phase 3 at level 6
    do_reset();
    walk_to(DOWN, 3, 6);
    step(16'h007F, 1);
    chk("kick_pulse", kick, 1);
    chk("kick_phase", phase, 2);
    chk("kick_state", state, UP);
    run_until_done();
    chk("kick_seq_cnt", seq_cnt, 1);

    // Non-thermometer word, then a later bad step keeps code 1
    do_reset();
    walk_to(UP, 0, 4);
    step(16'h0005, 1);
    chk("nontherm_err", err, 1);
    chk("nontherm_code", err_code, 1);
    chk("nontherm_state", state, SYNC);
    step(16'h0000, 1);
    chk("sync_to_idle", state, IDLE);
    step(16'h0001, 1);
    step(16'h0007, 1);
    chk("bad_step_err", err, 1);
    chk("code_sticky", err_code, 1);

    // Abort from 11 in phase 0
    do_reset();
    walk_to(UP, 0, 11);
    step(16'h0000, 1);
    chk("abort_pulse", abort, 1);
    chk("abort_no_err", err, 0);
    chk("abort_state", state, IDLE);

    // Overshoot past 11 in phase 2
    do_reset();
    walk_to(UP, 2, 11);
    step(therm(12), 1);
    chk("overshoot_err", err, 1);
    chk("overshoot_code", err_code, 3);

    // Asynchronous reset mid-sequence at level 9
    do_reset();
    walk_to(UP, 0, 9);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_state", state, IDLE);
    chk("async_rst_phase", phase, 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(16'h01FF, 1);
    chk("post_rst_err", err, 1);
    chk("post_rst_code", err_code, 2);
    chk("post_rst_state", state, SYNC);

`ifdef BF_MON_FLICK_CHECK_EN
    do_reset();
    step(16'd0, 0);
    step(16'd0, 0);
    step(16'd1, 0);
    chk("flick_missing_err", err, 1);
    chk("flick_missing_code", err_code, 4);
    step(16'd0, 0);
    step(16'd0, 1);
    step(16'd1, 0);
    chk("flick_start_state", state, UP);
    chk("flick_start_phase", phase, 0);
`endif

    // Randomized segments, each from a fresh reset
    for (int s = 0; s < 8; s++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        pick(8, 30, w, f);
        step(w, f);
      end
    end

    // Saturation of seq_cnt
    do_reset();
    for (int s = 0; s < 258; s++) run_until_done();
    chk("seq_cnt_saturated", seq_cnt, 255);
    chk("done_at_saturation", done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
